// File: rtl/period_running_sum_if.sv
// Signal bundle between the period measurer and the moving-average filter
// that consumes its running sum.
interface period_running_sum_if #(
    parameter int unsigned DATA_BITS = 32
);
    logic                        FREQ_IN;
    logic signed [DATA_BITS-1:0] OUT_VALUE;
    logic                        OUT_CE;
    logic                        STALLED;

    modport master (
        input  FREQ_IN,
        output OUT_VALUE,
        output OUT_CE,
        output STALLED
    );

    modport slave (
        output FREQ_IN,
        input  OUT_VALUE,
        input  OUT_CE,
        input  STALLED
    );
endinterface

// File: rtl/period_running_sum.sv
// Measures rising-edge to rising-edge periods of an asynchronous oscillator
// and accumulates the accepted ones into a wrapping running sum.
module period_running_sum #(
    parameter int unsigned DATA_BITS  = 32,
    parameter int unsigned MIN_PERIOD = 16,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic                 CLK,
    input  logic                 RESET,
    period_running_sum_if.master bus
);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        RUNNING,
        STALL
    } state_t;

    localparam logic [DATA_BITS-1:0] MIN_C     = DATA_BITS'(MIN_PERIOD);
    localparam logic [DATA_BITS-1:0] TIMEOUT_C = DATA_BITS'(TIMEOUT);
    localparam logic [DATA_BITS-1:0] ONE_C     = DATA_BITS'(1);

    // The sum is only ever differenced downstream, so plain modular wrap is safe.
    function automatic logic signed [DATA_BITS-1:0] wrap_add(
        input logic signed [DATA_BITS-1:0] sum,
        input logic        [DATA_BITS-1:0] period
    );
        logic [DATA_BITS-1:0] s;
        s = $unsigned(sum) + period;
        return $signed(s);
    endfunction

    function automatic logic [DATA_BITS-1:0] sat_inc(input logic [DATA_BITS-1:0] c);
        return (c >= TIMEOUT_C) ? TIMEOUT_C : c + ONE_C;
    endfunction

    logic                        sync_p0, sync_p1, sync_p2;
    logic                        vld_p0, vld_p1, vld_p2;
    logic                        edge_p2;
    state_t                      state;
    logic [DATA_BITS-1:0]        cnt;
    logic signed [DATA_BITS-1:0] sum_q;
    logic                        ce_q;
    logic                        stalled_q;

    // vld_pN marks synchronizer stages holding a post-reset sample, so a
    // FREQ_IN already high when reset falls cannot fake a rising edge.
    assign edge_p2 = vld_p2 & sync_p1 & ~sync_p2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            sync_p2   <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            state     <= WAIT_FIRST;
            cnt       <= '0;
            sum_q     <= '0;
            ce_q      <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            // p0/p1: metastability synchronizer, p2: edge-detect history
            sync_p0 <= bus.FREQ_IN;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            ce_q    <= 1'b0;

            case (state)
                WAIT_FIRST, STALL: begin
                    if (edge_p2) begin
                        state     <= RUNNING;
                        cnt       <= ONE_C;
                        stalled_q <= 1'b0;
                    end
                end
                RUNNING: begin
                    if (edge_p2 && cnt >= MIN_C) begin
                        sum_q <= wrap_add(sum_q, cnt);
                        ce_q  <= 1'b1;
                        cnt   <= ONE_C;
                    end else if (!edge_p2 && cnt == TIMEOUT_C) begin
                        state     <= STALL;
                        stalled_q <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: state <= WAIT_FIRST;
            endcase
        end
    end

    assign bus.OUT_VALUE = sum_q;
    assign bus.OUT_CE    = ce_q;
    assign bus.STALLED   = stalled_q;

endmodule

// File: tb/tb_period_running_sum.sv
// Bench for period_running_sum: directed edge tables plus randomized waveforms
// checked every cycle against a timestamp-based reference model.
module tb_period_running_sum;

    logic CLK;
    logic RESET;
    logic fa, fb;
    bit   chk_on;
    int   n_tests, n_fail;

    localparam int     M_MIN  [2] = '{16, 16};
    localparam int     M_TO   [2] = '{1000, 255};
    localparam longint M_MASK [2] = '{64'hFFFF_FFFF, 64'hFF};

    period_running_sum_if #(.DATA_BITS(32)) ifa ();
    period_running_sum_if #(.DATA_BITS(8))  ifb ();
    assign ifa.FREQ_IN = fa;
    assign ifb.FREQ_IN = fb;

    period_running_sum #(.DATA_BITS(32), .MIN_PERIOD(16), .TIMEOUT(1000)) dut_a (
        .CLK(CLK), .RESET(RESET), .bus(ifa.master)
    );
    period_running_sum #(.DATA_BITS(8), .MIN_PERIOD(16), .TIMEOUT(255)) dut_b (
        .CLK(CLK), .RESET(RESET), .bus(ifb.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] cur_val(input int d);
        return (d == 0) ? {32'b0, $unsigned(ifa.OUT_VALUE)} : {56'b0, $unsigned(ifb.OUT_VALUE)};
    endfunction
    function automatic logic cur_ce(input int d);
        return (d == 0) ? ifa.OUT_CE : ifb.OUT_CE;
    endfunction
    function automatic logic cur_st(input int d);
        return (d == 0) ? ifa.STALLED : ifb.STALLED;
    endfunction
    function automatic logic [63:0] act_pack(input int d);
        logic [63:0] r;
        r     = cur_val(d);
        r[63] = cur_ce(d);
        r[62] = cur_st(d);
        return r;
    endfunction

    // Reference model: edges are time-stamped by cycle number; a period is the
    // distance between stamps, stall fires when a gap reaches TIMEOUT.
    longint mcyc;
    bit     m_h    [2][3];
    int     m_n    [2];
    bit     m_run  [2];
    bit     m_ce   [2];
    bit     m_st   [2];
    longint m_last [2];
    longint m_acc  [2];

    task automatic model_step(input int d, input bit rst, input bit fin);
        bit edge_now;
        if (rst) begin
            m_n[d] = 0;
            for (int k = 0; k < 3; k++) m_h[d][k] = 1'b0;
            m_run[d] = 1'b0; m_ce[d] = 1'b0; m_st[d] = 1'b0; m_acc[d] = 0;
            return;
        end
        edge_now = (m_n[d] >= 3) && m_h[d][1] && !m_h[d][2];
        m_ce[d] = 1'b0;
        if (!m_run[d]) begin
            if (edge_now) begin
                m_run[d] = 1'b1; m_st[d] = 1'b0; m_last[d] = mcyc;
            end
        end else if (edge_now && (mcyc - m_last[d]) >= M_MIN[d]) begin
            m_acc[d]  = (m_acc[d] + (mcyc - m_last[d])) & M_MASK[d];
            m_ce[d]   = 1'b1;
            m_last[d] = mcyc;
        end else if (!edge_now && (mcyc - m_last[d]) >= M_TO[d]) begin
            m_run[d] = 1'b0; m_st[d] = 1'b1;
        end
        m_h[d][2] = m_h[d][1];
        m_h[d][1] = m_h[d][0];
        m_h[d][0] = fin;
        if (m_n[d] < 3) m_n[d]++;
    endtask

    function automatic logic [63:0] model_pack(input int d);
        logic [63:0] r;
        r     = m_acc[d];
        r[63] = m_ce[d];
        r[62] = m_st[d];
        return r;
    endfunction

    always @(posedge CLK) begin
        model_step(0, RESET, fa);
        model_step(1, RESET, fb);
        mcyc++;
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            check("model_a", act_pack(0), model_pack(0));
            check("model_b", act_pack(1), model_pack(1));
        end
    end

    task automatic drive(input int d, input logic v);
        if (d == 0) fa = v;
        else        fb = v;
    endtask

    // One rising edge followed by len-1 cycles before the next one; optional
    // one-cycle glitch pulse at offset glitch. Entered on a negedge.
    task automatic run_rise(input int d, input int len, input int glitch, input bit chk,
                            input bit exp_ce, input longint exp_val);
        int h;
        h = (glitch > 0 || len > 100) ? 2 : len / 2;
        for (int i = 0; i < len; i++) begin
            drive(d, (i < h) || (glitch > 0 && i == glitch));
            @(negedge CLK);
            // Strobe lands in the fourth cycle counting the one where FREQ_IN rose.
            if (chk && i == 2) begin
                check((d == 0) ? "a_ce" : "b_ce", {63'b0, cur_ce(d)}, {63'b0, exp_ce});
                check((d == 0) ? "a_val" : "b_val", cur_val(d), exp_val);
                check((d == 0) ? "a_stl" : "b_stl", {63'b0, cur_st(d)}, 64'd0);
            end
            if (chk && len > M_TO[d] + 10 && i == M_TO[d] + 1)
                check("stall_early", {63'b0, cur_st(d)}, 64'd0);
            if (chk && len > M_TO[d] + 10 && i == M_TO[d] + 2)
                check("stall_set", {63'b0, cur_st(d)}, 64'd1);
        end
    endtask

    typedef struct {
        int     len;
        int     glitch;
        bit     exp_ce;
        longint exp_val;
    } vec_t;
    vec_t tbl [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] prev, cur;
        RESET = 1'b1; fa = 1'b0; fb = 1'b0;
        tbl[0] = '{20,   0, 1'b0, 0};
        tbl[1] = '{20,   0, 1'b1, 20};
        tbl[2] = '{20,   0, 1'b1, 40};
        tbl[3] = '{40,   5, 1'b1, 60};
        tbl[4] = '{40,   0, 1'b1, 100};
        tbl[5] = '{1000, 0, 1'b1, 140};
        tbl[6] = '{1200, 0, 1'b1, 1140};
        tbl[7] = '{30,   0, 1'b0, 1140};
        tbl[8] = '{30,   0, 1'b1, 1170};
        tbl[9] = '{20,   0, 1'b1, 1200};

        repeat (3) @(negedge CLK);
        chk_on = 1'b1;
        check("rst_a", act_pack(0), 64'd0);
        check("rst_b", act_pack(1), 64'd0);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);

        for (int k = 0; k < 10; k++)
            run_rise(0, tbl[k].len, tbl[k].glitch, 1'b1, tbl[k].exp_ce, tbl[k].exp_val);

        // Reset lands on the cycle an accepted edge is detected, FREQ_IN stays high.
        drive(0, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_on_edge", act_pack(0), 64'd0);
        RESET = 1'b0;
        repeat (10) @(negedge CLK);
        drive(0, 1'b0);
        repeat (10) @(negedge CLK);
        run_rise(0, 25, 0, 1'b1, 1'b0, 0);
        run_rise(0, 20, 0, 1'b1, 1'b1, 25);

        // Narrow sum: wraps past 255, differences stay 50 mod 256.
        run_rise(1, 50, 0, 1'b1, 1'b0, 0);
        prev = 64'd0;
        for (int k = 1; k <= 10; k++) begin
            run_rise(1, 50, 0, 1'b1, 1'b1, (50 * k) % 256);
            cur = cur_val(1);
            check("b_diff", (cur - prev) & 64'hFF, 64'd50);
            prev = cur;
        end

        fork
            begin
                int len, g;
                repeat (30) begin
                    len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(995, 1005))
                                                       : int'($urandom_range(2, 60));
                    g = (len >= 10 && $urandom_range(0, 3) == 0) ? int'($urandom_range(3, len - 2)) : 0;
                    run_rise(0, len, g, 1'b0, 1'b0, 0);
                end
            end
            begin
                int len, g;
                repeat (30) begin
                    len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 260))
                                                       : int'($urandom_range(2, 80));
                    g = (len >= 10 && $urandom_range(0, 3) == 0) ? int'($urandom_range(3, len - 2)) : 0;
                    run_rise(1, len, g, 1'b0, 1'b0, 0);
                end
            end
            begin
                repeat ($urandom_range(300, 900)) @(negedge CLK);
                RESET = 1'b1;
                @(negedge CLK);
                RESET = 1'b0;
            end
        join

        repeat (5) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/period_running_sum.md
PERIOD_RUNNING_SUM -- requirements
Module: period_running_sum

Interface
REQ-001 Parameter DATA_BITS, default 32: width of running-sum output.
REQ-002 Parameter MIN_PERIOD, default 16: shortest accepted edge-to-edge period, in CLK cycles; shorter edges are glitches.
REQ-003 Parameter TIMEOUT, default 65535: longest accepted period, in CLK cycles; range MIN_PERIOD..2^DATA_BITS-1.
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 FREQ_IN  in  1  asynchronous oscillator signal; rising edges are measured.
REQ-007 OUT_VALUE  out  DATA_BITS  signed running sum of accepted periods; feeds the moving-average filter IN_VALUE.
REQ-008 OUT_CE  out  1  one-cycle strobe: OUT_VALUE updated this cycle; feeds the filter CE.
REQ-009 STALLED  out  1  high while no valid edge has arrived within TIMEOUT cycles.

Function
REQ-010 FREQ_IN SHALL pass through a 2-FF synchronizer, then a third register for edge detection; edge pulse = sync2 high AND sync3 low, one cycle wide.
REQ-011 States SHALL be WAIT_FIRST, RUNNING and STALL.
REQ-012 Period counter: an accepted or first edge in cycle N sets it to 1 at cycle N+1; it increments by 1 each cycle after that and saturates at TIMEOUT.
REQ-013 The counter value seen in an edge cycle is the period, equal to the cycle distance between the two edge pulses.
REQ-014 WAIT_FIRST: an edge clears the counter, moves to RUNNING, gives no OUT_CE and leaves OUT_VALUE unchanged.
REQ-015 RUNNING: an edge with period < MIN_PERIOD is ignored; the counter is not cleared, OUT_CE stays 0, the state is unchanged.
REQ-016 RUNNING: an edge with MIN_PERIOD <= period <= TIMEOUT gives OUT_VALUE <= OUT_VALUE + period and OUT_CE = 1 in the next cycle, and clears the counter.
REQ-017 RUNNING: counter == TIMEOUT with no edge in that cycle moves to STALL and sets STALLED = 1 in the next cycle; no OUT_CE.
REQ-018 Edge and counter == TIMEOUT in the same cycle: the edge wins and is accepted with period = TIMEOUT; no stall.
REQ-019 STALL: the next edge is handled as in WAIT_FIRST; STALLED clears in the next cycle and OUT_VALUE is kept.
REQ-020 Period is zero-extended to DATA_BITS. The addition wraps modulo 2^DATA_BITS with no saturation, because the downstream difference is wrap-safe.
REQ-021 OUT_VALUE, OUT_CE and STALLED SHALL be registered outputs.
REQ-022 Latency from a FREQ_IN rising edge (setup met) to OUT_CE is 4 CLK cycles.
REQ-023 OUT_CE SHALL never be high in two consecutive cycles, since MIN_PERIOD >= 2.

Reset
REQ-024 RESET high SHALL give, in the next cycle: OUT_VALUE = 0, OUT_CE = 0, STALLED = 0, state WAIT_FIRST, counter = 0, synchronizer and edge registers = 0.
REQ-025 RESET SHALL take priority over every other event, including a simultaneous edge.
REQ-026 Reset mid-period SHALL discard the partial period.
REQ-027 After RESET falls, a FREQ_IN already high SHALL NOT give an edge until it goes low and then high again.

Verification
REQ-028 Reset, then FREQ_IN square wave with period 20 CLK -> first edge gives no strobe; then OUT_CE every 20 cycles, OUT_VALUE 20, 40, 60...
REQ-029 Period-40 wave plus a 1-cycle glitch pulse 5 cycles after an edge -> glitch ignored; next OUT_VALUE step is exactly 40.
REQ-030 TIMEOUT = 1000, FREQ_IN held low 1200 cycles after an accepted edge -> STALLED = 1 one cycle after counter reaches 1000; the next edge gives no strobe and clears STALLED; the edge after that accumulates its true period.
REQ-031 TIMEOUT = 1000, edge exactly 1000 cycles after the previous one -> accepted, +1000, STALLED stays 0.
REQ-032 DATA_BITS = 8, period 50, run 10 strobes -> OUT_VALUE wraps (250 -> 44); consecutive differences are always 50 mod 256.
REQ-033 RESET asserted in the cycle of an accepted edge -> no OUT_CE; OUT_VALUE = 0; the next edge is treated as first.
